// File: rtl/leve1_axir_arb_pkg.sv
// Shared types for the LEVE1 AXI read-channel arbiter: FSM state encoding
// and the AXI read response codes used by the target.
package leve1_axir_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR_I = 3'd1,
        AR_D = 3'd2,
        R_I  = 3'd3,
        R_D  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/leve1_rr_arb2.sv
// Two-way round-robin grant. Bit 0 is the I side, bit 1 the D side.
// The grant is combinational from the requests and the last winner; the
// last winner only moves when the caller commits a grant through upd.
module leve1_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // last = 1 means the D side won most recently; reset favours I on the first tie
    logic last;

    // One-hot grant: a lone requester wins, a tie goes to the side that did not win last
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner whenever a grant is committed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (upd && (req != 2'b00)) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/leve1_axir_arb.sv
// LEVE1 AXI read-channel arbiter: instruction fetch (I) and load unit (D)
// share one target read port. One transaction is outstanding at a time and
// the owner keeps the target from its AR handshake through its RLAST beat.
// Address and read data are steered purely by the registered state, so the
// block adds no buffering and no path from the R channel into the AR channel.
module leve1_axir_arb
    import leve1_axir_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          I_ARVALID,
    input  logic [AW-1:0] I_ARADDR,
    input  logic [7:0]    I_ARLEN,
    output logic          I_ARREADY,
    output logic          I_RVALID,
    output logic [DW-1:0] I_RDATA,
    output logic [1:0]    I_RRESP,
    output logic          I_RLAST,
    input  logic          I_RREADY,

    input  logic          D_ARVALID,
    input  logic [AW-1:0] D_ARADDR,
    input  logic [7:0]    D_ARLEN,
    output logic          D_ARREADY,
    output logic          D_RVALID,
    output logic [DW-1:0] D_RDATA,
    output logic [1:0]    D_RRESP,
    output logic          D_RLAST,
    input  logic          D_RREADY,

    output logic          M_ARVALID,
    output logic [AW-1:0] M_ARADDR,
    output logic [7:0]    M_ARLEN,
    input  logic          M_ARREADY,
    input  logic          M_RVALID,
    input  logic [DW-1:0] M_RDATA,
    input  logic [1:0]    M_RRESP,
    input  logic          M_RLAST,
    output logic          M_RREADY,

    output logic          GNT_D
);

    state_t     state;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       ar_hs;
    logic       r_done;
    logic       in_r;
    logic       arb_upd;

    assign req    = {D_ARVALID, I_ARVALID};
    assign ar_hs  = M_ARVALID & M_ARREADY;
    assign in_r   = (state == R_I) || (state == R_D);
    // M_RREADY is already zero outside a data phase, so this only fires for the owner's last beat
    assign r_done = M_RVALID & M_RREADY & M_RLAST;
    // Grants are committed from IDLE and at the end of a burst (back-to-back handover)
    assign arb_upd = (state == IDLE) || r_done;

    leve1_rr_arb2 u_rr (
        .clk (CLK),
        .rst (RST),
        .req (req),
        .upd (arb_upd),
        .gnt (gnt)
    );

    // Ownership FSM: grant, address phase, data phase, and direct handover on RLAST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            GNT_D <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt[1]) begin
                        state <= AR_D;
                        GNT_D <= 1'b1;
                    end else if (gnt[0]) begin
                        state <= AR_I;
                        GNT_D <= 1'b0;
                    end
                end
                AR_I: if (ar_hs) state <= R_I;
                AR_D: if (ar_hs) state <= R_D;
                R_I, R_D: begin
                    if (r_done) begin
                        if (gnt[1]) begin
                            state <= AR_D;
                            GNT_D <= 1'b1;
                        end else if (gnt[0]) begin
                            state <= AR_I;
                            GNT_D <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Steer AR from the owner and R back to it; everything else is held at zero
    always_comb begin
        M_ARVALID = 1'b0;
        M_ARADDR  = '0;
        M_ARLEN   = '0;
        I_ARREADY = 1'b0;
        D_ARREADY = 1'b0;
        I_RVALID  = 1'b0;
        I_RDATA   = '0;
        I_RRESP   = '0;
        I_RLAST   = 1'b0;
        D_RVALID  = 1'b0;
        D_RDATA   = '0;
        D_RRESP   = '0;
        D_RLAST   = 1'b0;
        M_RREADY  = 1'b0;
        case (state)
            AR_I: begin
                M_ARVALID = I_ARVALID;
                M_ARADDR  = I_ARADDR;
                M_ARLEN   = I_ARLEN;
                I_ARREADY = M_ARREADY;
            end
            AR_D: begin
                M_ARVALID = D_ARVALID;
                M_ARADDR  = D_ARADDR;
                M_ARLEN   = D_ARLEN;
                D_ARREADY = M_ARREADY;
            end
            R_I: begin
                I_RVALID = M_RVALID;
                I_RDATA  = M_RDATA;
                I_RRESP  = M_RRESP;
                I_RLAST  = M_RLAST;
                M_RREADY = I_RREADY;
            end
            R_D: begin
                D_RVALID = M_RVALID;
                D_RDATA  = M_RDATA;
                D_RRESP  = M_RRESP;
                D_RLAST  = M_RLAST;
                M_RREADY = D_RREADY;
            end
            default: ;
        endcase
    end

    // A target beat with no open data phase is a protocol error on the target side
    a_no_spurious_beat: assert property (@(posedge CLK) disable iff (RST) M_RVALID |-> in_r)
        else $error("leve1_axir_arb: M_RVALID asserted with no data phase open");

endmodule

// File: doc/leve1_axir_arb.md
Name: leve1_axir_arb

Overview:
- Two-initiator, one-target arbiter for the LEVE1 AXI read channel (AXIR).
- Shares one memory read port between instruction fetch (I side, LEVE1_IF) and the upcoming load unit (D side).
- At most one transaction outstanding; a granted transaction owns the target from the AR handshake through the RLAST beat.
- Round-robin grant; address and read data are routed to and from the owner.

Parameters:
- AW, 32, address width (matches `XLEN).
- DW, 32, read data width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- I_ARVALID, D_ARVALID  in  1  initiator address valid.
- I_ARADDR, D_ARADDR  in  AW  initiator address.
- I_ARLEN, D_ARLEN  in  8  initiator burst length minus one.
- I_ARREADY, D_ARREADY  out  1  address accepted.
- I_RVALID, D_RVALID  out  1  read beat valid.
- I_RDATA, D_RDATA  out  DW  read data.
- I_RRESP, D_RRESP  out  2  read response.
- I_RLAST, D_RLAST  out  1  final beat.
- I_RREADY, D_RREADY  in  1  initiator accepts beat.
- M_ARVALID  out  1  target address valid.
- M_ARADDR  out  AW  target address.
- M_ARLEN  out  8  target burst length.
- M_ARREADY  in  1  target accepts address.
- M_RVALID, M_RDATA, M_RRESP, M_RLAST  in  1/DW/2/1  target read beat.
- M_RREADY  out  1  beat accepted.
- GNT_D  out  1  current/last owner is D (debug).

Behaviour:
- State register, one of five states:
  - IDLE: no owner.
  - AR_I, AR_D: address phase of owner.
  - R_I, R_D: data phase of owner.
- Reset (RST high, async) puts the block in IDLE with last_gnt=D and GNT_D=0.
  - During reset all valid, ready and RLAST outputs are 0.
  - M_ARADDR and M_ARLEN are 0; I_/D_ RDATA and RRESP are 0.
- Arbitration uses req_I=I_ARVALID and req_D=D_ARVALID.
  - One requester: it wins.
  - Both: the side other than last_gnt wins, so the first tie after reset goes to I.
  - The winner is written to last_gnt and GNT_D.
- IDLE transitions:
  - Any request moves to AR_winner on the next edge.
  - Latency is one cycle: the request in cycle n gives M_ARVALID=1 in cycle n+1.
- AR_x phase:
  - M_ARVALID, M_ARADDR and M_ARLEN are driven combinationally from x; x_ARREADY=M_ARREADY.
  - The non-owner's ARREADY is 0.
  - M_ARVALID&M_ARREADY moves to R_x.
  - x must hold ARVALID and address stable until the handshake (AXI rule). A deasserted ARVALID leaves the state unchanged; this is not a supported case.
- R_x phase:
  - x_RVALID=M_RVALID; x_RDATA, x_RRESP and x_RLAST come from M; M_RREADY=x_RREADY.
  - The non-owner sees RVALID=0, RLAST=0 and data 0.
  - M_ARVALID=0.
- End of burst (M_RVALID&M_RREADY&M_RLAST in R_x):
  - Re-arbitrate combinationally on the same cycle's requests, with x as last_gnt.
  - Go directly to AR_winner with no bubble, or to IDLE if there are no requests.
- Multi-beat bursts: ownership is held across all beats; the beat count is not checked, and RLAST alone ends the phase.
- Stalls: an RREADY=0 backpressure from the owner is passed through; the arbiter adds no buffering and no combinational path from M_R* to M_AR*.
- A requester stalled by the other's burst is never starved: round-robin bounds its wait to one transaction.
- Reset mid-transaction returns to IDLE immediately. Target and initiators share RST, so an in-flight burst is abandoned with no recovery.
- M_RVALID outside R_x is ignored: M_RREADY=0 and no initiator RVALID is raised. An assertion flags this error.

Decomposition:
- A shared package holds the state typedef (IDLE, AR_I, AR_D, R_I, R_D) and the RRESP encodings (OKAY=2'b00, SLVERR=2'b10).
- One natural sub-module: leve1_rr_arb2, the 2-way round-robin grant with a last_gnt register and update enable. It is reused by the future write arbiter.

Test Plan:
- I only, single beat: I_ARVALID=1, ADDR=0x100 in cycle 0 → M_ARVALID=1, M_ARADDR=0x100 in cycle 1; ARREADY=1 → R_I; RDATA=0xDEADBEEF with RLAST → I_RVALID=1, D_RVALID=0, state returns to IDLE.
- Simultaneous requests after reset: I=0x100, D=0x200 both in cycle 0 → I granted first. On I's RLAST, M_ARADDR=0x200 on the next cycle with no IDLE bubble; GNT_D=1.
- Burst hold: D ARLEN=3 with 4 beats, I requesting throughout → M_ARVALID stays 0 until D's 4th beat with RLAST, then I is granted.
- Backpressure: the owner holds RREADY=0 for 3 cycles with M_RVALID=1 → M_RREADY=0 for those cycles; data stable and delivered once on release.
- Reset mid-burst: RST pulsed during R_D beat 2 → all outputs 0 asynchronously; after release, the first tie is granted to I.
- Spurious target beat: M_RVALID=1 in IDLE → M_RREADY=0, I_/D_RVALID=0, assertion fires.
